// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline (ID->EX->MEM->WB) with load-use stall, taken-branch flush,
// EX operand forwarding selects and saturating stall/flush event counters.
module ctrl_pipe_hazard #(
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_Branch,
  input  logic               id_MemRead,
  input  logic               id_MemtoReg,
  input  logic               id_MemWrite,
  input  logic               id_ALUSrc,
  input  logic               id_RegWrite,
  input  logic [1:0]         id_ALUOp,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               ex_branch_taken,
  output logic               ex_ALUSrc,
  output logic               ex_Branch,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_MemtoReg,
  output logic               ex_RegWrite,
  output logic [1:0]         ex_ALUOp,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               mem_MemtoReg,
  output logic               mem_RegWrite,
  output logic               wb_MemtoReg,
  output logic               wb_RegWrite,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [RADDR_W-1:0] mem_rd,
  output logic [RADDR_W-1:0] wb_rd,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic [1:0]         forward_a,
  output logic [1:0]         forward_b,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [RADDR_W-1:0] IDX_ZERO = {RADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic               ex_alusrc_r, ex_branch_r, ex_memread_r, ex_memwrite_r;
  logic               ex_memtoreg_r, ex_regwrite_r;
  logic [1:0]         ex_aluop_r;
  logic [RADDR_W-1:0] ex_rs1_r, ex_rs2_r, ex_rd_r;
  logic               mem_memread_r, mem_memwrite_r, mem_memtoreg_r, mem_regwrite_r;
  logic [RADDR_W-1:0] mem_rd_r;
  logic               wb_memtoreg_r, wb_regwrite_r;
  logic [RADDR_W-1:0] wb_rd_r;
  logic [CNT_W-1:0]   stall_cnt_r, flush_cnt_r;
  logic               load_use_s, flush_s, stall_s, bubble_s;

  // MEM result is newer than WB, so a MEM match wins; index 0 never matches.
  function automatic logic [1:0] fwd_sel(
    input logic [RADDR_W-1:0] src,
    input logic               m_rw,
    input logic [RADDR_W-1:0] m_rd,
    input logic               w_rw,
    input logic [RADDR_W-1:0] w_rd
  );
    logic [1:0] sel;
    if (m_rw && (m_rd != IDX_ZERO) && (m_rd == src)) begin
      sel = 2'b10;
    end else if (w_rw && (w_rd != IDX_ZERO) && (w_rd == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection, pipeline write enables and forwarding selects.
  always_comb begin
    load_use_s = ex_memread_r && (ex_rd_r != IDX_ZERO) &&
                 ((ex_rd_r == id_rs1) || (ex_rd_r == id_rs2));
    flush_s    = ex_branch_r && ex_branch_taken;
    stall_s    = load_use_s && !flush_s;
    bubble_s   = load_use_s || flush_s;
    pc_write   = !stall_s;
    ifid_write = !stall_s;
    ifid_flush = flush_s;
    forward_a  = fwd_sel(ex_rs1_r, mem_regwrite_r, mem_rd_r, wb_regwrite_r, wb_rd_r);
    forward_b  = fwd_sel(ex_rs2_r, mem_regwrite_r, mem_rd_r, wb_regwrite_r, wb_rd_r);
  end

  // EX stage: takes the ID controls unless a stall or flush injects a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble_s) begin
      {ex_alusrc_r, ex_branch_r, ex_memread_r, ex_memwrite_r} <= 4'b0000;
      {ex_memtoreg_r, ex_regwrite_r}                          <= 2'b00;
      ex_aluop_r <= 2'b00;
      ex_rs1_r   <= IDX_ZERO;
      ex_rs2_r   <= IDX_ZERO;
      ex_rd_r    <= IDX_ZERO;
    end else begin
      {ex_alusrc_r, ex_branch_r, ex_memread_r, ex_memwrite_r} <=
        {id_ALUSrc, id_Branch, id_MemRead, id_MemWrite};
      {ex_memtoreg_r, ex_regwrite_r} <= {id_MemtoReg, id_RegWrite};
      ex_aluop_r <= id_ALUOp;
      ex_rs1_r   <= id_rs1;
      ex_rs2_r   <= id_rs2;
      ex_rd_r    <= id_rd;
    end
  end

  // MEM and WB always advance; hazards never hold or clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {mem_memread_r, mem_memwrite_r, mem_memtoreg_r, mem_regwrite_r} <= 4'b0000;
      mem_rd_r <= IDX_ZERO;
      {wb_memtoreg_r, wb_regwrite_r} <= 2'b00;
      wb_rd_r <= IDX_ZERO;
    end else begin
      {mem_memread_r, mem_memwrite_r, mem_memtoreg_r, mem_regwrite_r} <=
        {ex_memread_r, ex_memwrite_r, ex_memtoreg_r, ex_regwrite_r};
      mem_rd_r <= ex_rd_r;
      {wb_memtoreg_r, wb_regwrite_r} <= {mem_memtoreg_r, mem_regwrite_r};
      wb_rd_r <= mem_rd_r;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign ex_ALUSrc    = ex_alusrc_r;
  assign ex_Branch    = ex_branch_r;
  assign ex_MemRead   = ex_memread_r;
  assign ex_MemWrite  = ex_memwrite_r;
  assign ex_MemtoReg  = ex_memtoreg_r;
  assign ex_RegWrite  = ex_regwrite_r;
  assign ex_ALUOp     = ex_aluop_r;
  assign ex_rd        = ex_rd_r;
  assign mem_MemRead  = mem_memread_r;
  assign mem_MemWrite = mem_memwrite_r;
  assign mem_MemtoReg = mem_memtoreg_r;
  assign mem_RegWrite = mem_regwrite_r;
  assign mem_rd       = mem_rd_r;
  assign wb_MemtoReg  = wb_memtoreg_r;
  assign wb_RegWrite  = wb_regwrite_r;
  assign wb_rd        = wb_rd_r;
  assign stall_cnt    = stall_cnt_r;
  assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench for ctrl_pipe_hazard: a reference pipeline model queues the
// expected stage/counter state per cycle; hazard/forward outputs checked live.
module tb_ctrl_pipe_hazard;

  localparam int RW = 5;
  localparam int CW = 4;

  typedef struct packed {
    logic br, mr, m2r, mw, as, rw;
    logic [1:0] op;
    logic [RW-1:0] rs1, rs2, rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
  logic [1:0] id_ALUOp;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic ex_branch_taken;
  logic ex_ALUSrc, ex_Branch, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite;
  logic [1:0] ex_ALUOp;
  logic mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite;
  logic wb_MemtoReg, wb_RegWrite;
  logic [RW-1:0] ex_rd, mem_rd, wb_rd;
  logic pc_write, ifid_write, ifid_flush;
  logic [1:0] forward_a, forward_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ins_t          m_ex;
  logic [3:0]    m_mem_ctl;   // {MemRead, MemWrite, MemtoReg, RegWrite}
  logic [RW-1:0] m_mem_rd;
  logic [1:0]    m_wb_ctl;    // {MemtoReg, RegWrite}
  logic [RW-1:0] m_wb_rd;
  logic [CW-1:0] m_stall, m_flush;
  logic [63:0]   sbq[$];

  ctrl_pipe_hazard #(.RADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
    .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
    .id_ALUOp(id_ALUOp), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken),
    .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
    .ex_ALUOp(ex_ALUOp),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_MemtoReg(mem_MemtoReg), .mem_RegWrite(mem_RegWrite),
    .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({ex_ALUSrc, ex_Branch, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite,
                ex_ALUOp, ex_rd, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite,
                mem_rd, wb_MemtoReg, wb_RegWrite, wb_rd, stall_cnt, flush_cnt});
  endfunction

  function automatic logic [63:0] model_vec();
    return 64'({m_ex.as, m_ex.br, m_ex.mr, m_ex.mw, m_ex.m2r, m_ex.rw, m_ex.op, m_ex.rd,
                m_mem_ctl, m_mem_rd, m_wb_ctl, m_wb_rd, m_stall, m_flush});
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [RW-1:0] rs);
    if (rs != 5'd0 && m_mem_ctl[0] && m_mem_rd == rs) return 2'b10;
    if (rs != 5'd0 && m_wb_ctl[0] && m_wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic ins_t ld(input logic [RW-1:0] rd, input logic [RW-1:0] rs1);
    ins_t i = '0;
    i.mr = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.as = 1'b1; i.rd = rd; i.rs1 = rs1;
    return i;
  endfunction

  function automatic ins_t alu(input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                               input logic [RW-1:0] rs2, input logic wr);
    ins_t i = '0;
    i.rw = wr; i.mw = ~wr; i.op = 2'b10; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic ins_t brn(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
    ins_t i = '0;
    i.br = 1'b1; i.op = 2'b01; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  task automatic drive(input ins_t id, input logic taken);
    {id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite} =
      {id.br, id.mr, id.m2r, id.mw, id.as, id.rw};
    id_ALUOp = id.op; id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
    ex_branch_taken = taken;
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem_ctl = 4'd0; m_mem_rd = 5'd0; m_wb_ctl = 2'd0; m_wb_rd = 5'd0;
    m_stall = 4'd0; m_flush = 4'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stages"}, dut_vec(), 64'd0);
    check({tag, "_pc_write"}, 64'(pc_write), 64'd1);
    check({tag, "_ifid_write"}, 64'(ifid_write), 64'd1);
    check({tag, "_ifid_flush"}, 64'(ifid_flush), 64'd0);
    check({tag, "_fwd"}, 64'({forward_a, forward_b}), 64'd0);
  endtask

  // One pipeline cycle: live hazard checks, model step, scoreboard compare.
  task automatic cyc(input ins_t id, input logic taken);
    logic lu, fl;
    drive(id, taken);
    #2;
    fl = m_ex.br & taken;
    lu = m_ex.mr && (m_ex.rd != 5'd0) && (m_ex.rd == id.rs1 || m_ex.rd == id.rs2);
    check("pc_write", 64'(pc_write), 64'(!(lu && !fl)));
    check("ifid_write", 64'(ifid_write), 64'(!(lu && !fl)));
    check("ifid_flush", 64'(ifid_flush), 64'(fl));
    check("forward_a", 64'(forward_a), 64'(exp_fwd(m_ex.rs1)));
    check("forward_b", 64'(forward_b), 64'(exp_fwd(m_ex.rs2)));
    m_wb_ctl  = m_mem_ctl[1:0];
    m_wb_rd   = m_mem_rd;
    m_mem_ctl = {m_ex.mr, m_ex.mw, m_ex.m2r, m_ex.rw};
    m_mem_rd  = m_ex.rd;
    if (fl) begin
      if (m_flush != 4'hF) m_flush = m_flush + 4'd1;
    end else if (lu) begin
      if (m_stall != 4'hF) m_stall = m_stall + 4'd1;
    end
    m_ex = (fl || lu) ? ins_t'('0) : id;
    sbq.push_back(model_vec());
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      check("stage_regs", dut_vec(), sbq.pop_front());
    end
  endtask

  initial begin
    drive(ins_t'('0), 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load-use on rs1 = 5, then re-presented instruction proceeds
    cyc(ld(5'd5, 5'd1), 1'b0);
    cyc(alu(5'd6, 5'd5, 5'd2, 1'b1), 1'b0);
    check("stall_cnt_one", 64'(stall_cnt), 64'd1);
    cyc(alu(5'd6, 5'd5, 5'd2, 1'b1), 1'b0);
    // Load to x0 must not stall
    cyc(ld(5'd0, 5'd1), 1'b0);
    cyc(alu(5'd7, 5'd0, 5'd0, 1'b1), 1'b0);
    // Taken branch flushes, not-taken does not
    cyc(brn(5'd1, 5'd2), 1'b0);
    cyc(alu(5'd8, 5'd1, 5'd1, 1'b1), 1'b1);
    check("flush_cnt_one", 64'(flush_cnt), 64'd1);
    cyc(brn(5'd1, 5'd2), 1'b0);
    cyc(alu(5'd8, 5'd1, 5'd1, 1'b1), 1'b0);
    // Forwarding priority: MEM over WB, then WB when MEM does not write
    cyc(alu(5'd3, 5'd1, 5'd1, 1'b1), 1'b0);
    cyc(alu(5'd3, 5'd2, 5'd2, 1'b1), 1'b0);
    cyc(alu(5'd9, 5'd3, 5'd3, 1'b1), 1'b0);
    cyc(ins_t'('0), 1'b0);
    cyc(alu(5'd3, 5'd1, 5'd1, 1'b1), 1'b0);
    cyc(alu(5'd3, 5'd2, 5'd2, 1'b0), 1'b0);
    cyc(alu(5'd9, 5'd3, 5'd3, 1'b1), 1'b0);
    cyc(ins_t'('0), 1'b0);
    // Flush and load-use together: flush wins
    begin
      ins_t bl;
      bl = ld(5'd5, 5'd1);
      bl.br = 1'b1;
      cyc(bl, 1'b0);
      cyc(alu(5'd6, 5'd5, 5'd5, 1'b1), 1'b1);
    end
    // Random traffic on a small register set
    for (int k = 0; k < 150; k++) begin
      ins_t r;
      r = ins_t'($urandom);
      r.rs1 = 5'($urandom_range(0, 3));
      r.rs2 = 5'($urandom_range(0, 3));
      r.rd  = 5'($urandom_range(0, 3));
      cyc(r, 1'($urandom_range(0, 1)));
    end
    // Twenty stalls saturate the 4-bit counter
    for (int k = 0; k < 20; k++) begin
      cyc(ld(5'd7, 5'd1), 1'b0);
      cyc(alu(5'd2, 5'd7, 5'd1, 1'b1), 1'b0);
      cyc(alu(5'd2, 5'd7, 5'd1, 1'b1), 1'b0);
    end
    check("stall_cnt_sat", 64'(stall_cnt), 64'd15);

    // Asynchronous reset in the middle of a stall cycle
    cyc(ld(5'd7, 5'd1), 1'b0);
    drive(alu(5'd2, 5'd7, 5'd1, 1'b1), 1'b0);
    #2;
    check("pre_rst_stall", 64'(pc_write), 64'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(alu(5'd2, 5'd7, 5'd1, 1'b1), 1'b0);
    cyc(ins_t'('0), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_hazard.md
CTRL_PIPE_HAZARD -- requirements
Module: ctrl_pipe_hazard

Interface
REQ-001 Parameter RADDR_W, default 5, register-index width.
REQ-002 Parameter CNT_W, default 16, width of each event counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-high.
REQ-005 id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite  in  1 each  decoded ID-stage controls.
REQ-006 id_ALUOp  in  2  decoded ID-stage ALU op class.
REQ-007 id_rs1, id_rs2, id_rd  in  RADDR_W each  ID-stage register indices.
REQ-008 ex_branch_taken  in  1  EX branch comparison result; meaningful only while ex_Branch=1.
REQ-009 ex_ALUSrc, ex_Branch, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite  out  1 each  EX-stage controls.
REQ-010 ex_ALUOp  out  2  EX-stage ALU op class.
REQ-011 mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite  out  1 each  MEM-stage controls.
REQ-012 wb_MemtoReg, wb_RegWrite  out  1 each  WB-stage controls.
REQ-013 ex_rd, mem_rd, wb_rd  out  RADDR_W each  destination index per stage.
REQ-014 pc_write, ifid_write  out  1 each  PC / IF-ID register write enables.
REQ-015 ifid_flush  out  1  clear IF/ID register on next edge.
REQ-016 forward_a, forward_b  out  2 each  ALU operand source select: 00 register file, 10 MEM result, 01 WB result.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  event counters.

Function
REQ-018 Block SHALL hold three registered stages: EX (all id_* controls, rs1, rs2, rd), MEM (MemRead, MemWrite, MemtoReg, RegWrite, rd), WB (MemtoReg, RegWrite, rd); each advances one stage per cycle, latency ID->EX->MEM->WB = 1 cycle per stage.
REQ-019 load_use SHALL be combinational: ex_MemRead=1 and ex_rd!=0 and (ex_rd==id_rs1 or ex_rd==id_rs2).
REQ-020 flush SHALL be combinational: ex_Branch=1 and ex_branch_taken=1.
REQ-021 On flush: ifid_flush=1, pc_write=1, ifid_write=1, and EX stage SHALL load a bubble (all controls and rd zero) on the next edge.
REQ-022 On load_use without flush: pc_write=0, ifid_write=0, ifid_flush=0, and EX SHALL load a bubble on the next edge; ID contents are re-presented next cycle.
REQ-023 flush SHALL take priority over load_use when both are true in the same cycle; stall outputs remain deasserted.
REQ-024 Otherwise pc_write=1, ifid_write=1, ifid_flush=0, and EX loads id_* values.
REQ-025 MEM and WB SHALL always advance from EX and MEM respectively; stall and flush never freeze or clear them.
REQ-026 forward_a SHALL be 10 if mem_RegWrite=1, mem_rd!=0, mem_rd==EX rs1; else 01 if wb_RegWrite=1, wb_rd!=0, wb_rd==EX rs1; else 00; MEM match has priority over WB.
REQ-027 forward_b SHALL follow REQ-026 using EX rs2.
REQ-028 Index 0 SHALL never cause a hazard or forwarding match.
REQ-029 stall_cnt SHALL increment by 1 on each edge where REQ-022 applies; flush_cnt on each edge where REQ-021 applies; both saturate at all-ones (no wrap).

Reset
REQ-030 While rst=1, all stage registers and both counters SHALL be 0, independent of clk.
REQ-031 Consequently during and right after reset: all stage control outputs 0, all rd outputs 0, pc_write=1, ifid_write=1, ifid_flush=0, forward_a=forward_b=00.
REQ-032 Reset asserted mid-stall or mid-flush SHALL discard the pending bubble/flush; first post-reset cycle behaves per REQ-024.

Verification
REQ-033 Load-use: EX holds load rd=5; ID rs1=5 -> pc_write=0, ifid_write=0 for one cycle, next cycle ex_* all 0, stall_cnt=1.
REQ-034 Load to x0: EX load rd=0, ID rs1=0 -> no stall, pc_write=1, forward_a=00.
REQ-035 Taken branch: ex_Branch=1, ex_branch_taken=1 -> ifid_flush=1, next cycle ex_* all 0, flush_cnt=1; with ex_branch_taken=0 -> no flush.
REQ-036 Forward priority: MEM rd=3 RegWrite=1 and WB rd=3 RegWrite=1, EX rs1=3, rs2=3 -> forward_a=10, forward_b=10; MEM RegWrite=0 -> both 01.
REQ-037 Simultaneous: flush and load_use true in same cycle -> ifid_flush=1, pc_write=1, stall_cnt unchanged, flush_cnt+1.
REQ-038 Saturation/reset: force CNT_W=4, 20 stalls -> stall_cnt=15; assert rst asynchronously mid-stall -> all outputs per REQ-031 before next clk edge.
